fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline: PC register, PC+4 adder, and the IF/ID pipeline register. It sits directly upstream of the ID-stage hazard units. It consumes their combined stall, holds PC and IF/ID while a stall is active, and redirects fetch on taken branches and jumps resolved in ID, squashing the wrong-path instruction. It also drives the bubble request for the ID/EX register and keeps saturating stall and flush counters for performance debug.

---
 rtl/fetch_stage.sv | 78 +++++++
 tb/tb_fetch_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, PC+4 adder and the IF/ID pipeline register.
// Holds on stall, redirects on taken branch/jump resolved in ID, and squashes the wrong-path slot.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc4,
    output logic             id_valid,
    output logic             ex_bubble,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    logic [31:0]      pc_p0;
    logic [31:0]      pc4_p0;
    logic [31:0]      instr_p1;
    logic [31:0]      pc4_p1;
    logic             vld_p1;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // IF stage: PC and its increment (wraps modulo 2^32)
    assign pc4_p0 = pc_p0 + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0     <= RESET_PC;
            instr_p1  <= '0;
            pc4_p1    <= '0;
            vld_p1    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end else if (branch_taken) begin
            pc_p0     <= {branch_target[31:2], 2'b00};
            instr_p1  <= '0;
            pc4_p1    <= '0;
            vld_p1    <= 1'b0;
            flush_cnt <= sat_inc(flush_cnt);
        end else if (jump) begin
            pc_p0     <= {jump_target[31:2], 2'b00};
            instr_p1  <= '0;
            pc4_p1    <= '0;
            vld_p1    <= 1'b0;
            flush_cnt <= sat_inc(flush_cnt);
        end else begin
            pc_p0     <= pc4_p0;
            instr_p1  <= imem_data;
            pc4_p1    <= pc4_p0;
            vld_p1    <= 1'b1;
        end
    end

    // IF/ID boundary outputs
    assign imem_addr   = pc_p0;
    assign id_instr    = instr_p1;
    assign id_pc4      = pc4_p1;
    assign id_valid    = vld_p1;
    assign ex_bubble   = stall | ~vld_p1;
    assign stall_count = stall_cnt;
    assign flush_count = flush_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: three instances (default, top-of-memory reset PC, 4-bit counters)
// share stimulus; each instruction memory returns its address as data.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;

    logic [31:0] addr0, data0, instr0, pc40;
    logic        valid0, bub0;
    logic [15:0] scnt0, fcnt0;

    logic [31:0] addr1, data1, instr1, pc41;
    logic        valid1, bub1;
    logic [15:0] scnt1, fcnt1;

    logic [31:0] addr2, data2, instr2, pc42;
    logic        valid2, bub2;
    logic [3:0]  scnt2, fcnt2;

    int vectors = 0;
    int miscompares = 0;

    assign data0 = addr0;
    assign data1 = addr1;
    assign data2 = addr2;

    always #5 clk = ~clk;

    fetch_stage dut0 (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
        .imem_addr(addr0), .imem_data(data0), .id_instr(instr0), .id_pc4(pc40),
        .id_valid(valid0), .ex_bubble(bub0), .stall_count(scnt0), .flush_count(fcnt0)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
        .imem_addr(addr1), .imem_data(data1), .id_instr(instr1), .id_pc4(pc41),
        .id_valid(valid1), .ex_bubble(bub1), .stall_count(scnt1), .flush_count(fcnt1)
    );

    fetch_stage #(.CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
        .imem_addr(addr2), .imem_data(data2), .id_instr(instr2), .id_pc4(pc42),
        .id_valid(valid2), .ex_bubble(bub2), .stall_count(scnt2), .flush_count(fcnt2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        step(); step();
        vectors++; if (addr0 !== 32'h0) begin miscompares++; $display("FAIL reset_addr got %h want %h", addr0, 32'h0); end
        vectors++; if (instr0 !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %h want %h", instr0, 32'h0); end
        vectors++; if (pc40 !== 32'h0) begin miscompares++; $display("FAIL reset_pc4 got %h want %h", pc40, 32'h0); end
        vectors++; if (valid0 !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid0); end
        vectors++; if (scnt0 !== 16'd0 || fcnt0 !== 16'd0) begin miscompares++; $display("FAIL reset_counts got %0d/%0d want 0/0", scnt0, fcnt0); end
        vectors++; if (addr1 !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL reset_addr_top got %h want %h", addr1, 32'hFFFF_FFF8); end
        rst = 1'b0;
        #1;
        vectors++; if (bub0 !== 1'b1) begin miscompares++; $display("FAIL reset_bubble got %b want 1", bub0); end
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (instr0 !== 32'(4 * i)) begin miscompares++; $display("FAIL fetch_instr[%0d] got %h want %h", i, instr0, 32'(4 * i)); end
            vectors++; if (pc40 !== 32'(4 * i + 4)) begin miscompares++; $display("FAIL fetch_pc4[%0d] got %h want %h", i, pc40, 32'(4 * i + 4)); end
            vectors++; if (valid0 !== 1'b1 || bub0 !== 1'b0) begin miscompares++; $display("FAIL fetch_valid[%0d] got v=%b b=%b want v=1 b=0", i, valid0, bub0); end
            vectors++; if (addr0 !== 32'(4 * i + 4)) begin miscompares++; $display("FAIL fetch_addr[%0d] got %h want %h", i, addr0, 32'(4 * i + 4)); end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bub0 !== 1'b1) begin miscompares++; $display("FAIL stall_bubble[%0d] got %b want 1", i, bub0); end
            step();
            vectors++; if (instr0 !== 32'h8 || addr0 !== 32'hC) begin miscompares++; $display("FAIL stall_hold[%0d] got instr=%h addr=%h want 8/c", i, instr0, addr0); end
        end
        vectors++; if (scnt0 !== 16'd3 || fcnt0 !== 16'd0) begin miscompares++; $display("FAIL stall_count got %0d/%0d want 3/0", scnt0, fcnt0); end
        stall = 1'b0;
        #1;
        vectors++; if (bub0 !== 1'b0) begin miscompares++; $display("FAIL stall_release_bubble got %b want 0", bub0); end
        step();
        vectors++; if (instr0 !== 32'hC || pc40 !== 32'h10 || addr0 !== 32'h10) begin miscompares++; $display("FAIL stall_resume got instr=%h pc4=%h addr=%h want c/10/10", instr0, pc40, addr0); end
        vectors++; if (scnt0 !== 16'd3) begin miscompares++; $display("FAIL stall_count_after got %0d want 3", scnt0); end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; branch_target = 32'h0000_0103;
        step();
        branch_taken = 1'b0;
        vectors++; if (addr0 !== 32'h100) begin miscompares++; $display("FAIL branch_addr got %h want 100", addr0); end
        vectors++; if (valid0 !== 1'b0 || instr0 !== 32'h0 || bub0 !== 1'b1) begin miscompares++; $display("FAIL branch_squash got v=%b instr=%h b=%b want 0/0/1", valid0, instr0, bub0); end
        vectors++; if (fcnt0 !== 16'd1) begin miscompares++; $display("FAIL branch_flush got %0d want 1", fcnt0); end
        step();
        vectors++; if (instr0 !== 32'h100 || pc40 !== 32'h104 || valid0 !== 1'b1) begin miscompares++; $display("FAIL branch_target_instr got %h/%h/%b want 100/104/1", instr0, pc40, valid0); end
    endtask

    task automatic test_stall_priority();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h200; jump = 1'b1; jump_target = 32'h300;
        step();
        vectors++; if (addr0 !== 32'h104 || instr0 !== 32'h100 || valid0 !== 1'b1) begin miscompares++; $display("FAIL prio_hold got addr=%h instr=%h v=%b want 104/100/1", addr0, instr0, valid0); end
        vectors++; if (fcnt0 !== 16'd1 || scnt0 !== 16'd4) begin miscompares++; $display("FAIL prio_counts got %0d/%0d want s4/f1", scnt0, fcnt0); end
        stall = 1'b0;
        step();
        branch_taken = 1'b0; jump = 1'b0;
        vectors++; if (addr0 !== 32'h200 || valid0 !== 1'b0 || fcnt0 !== 16'd2) begin miscompares++; $display("FAIL prio_branch_wins got addr=%h v=%b f=%0d want 200/0/2", addr0, valid0, fcnt0); end
        step();
        vectors++; if (instr0 !== 32'h200) begin miscompares++; $display("FAIL prio_target_instr got %h want 200", instr0); end
    endtask

    task automatic test_jump();
        jump = 1'b1; jump_target = 32'h0000_0403;
        step();
        jump = 1'b0;
        vectors++; if (addr0 !== 32'h400 || valid0 !== 1'b0 || fcnt0 !== 16'd3) begin miscompares++; $display("FAIL jump_redirect got addr=%h v=%b f=%0d want 400/0/3", addr0, valid0, fcnt0); end
        step();
        vectors++; if (instr0 !== 32'h400 || pc40 !== 32'h404) begin miscompares++; $display("FAIL jump_target_instr got %h/%h want 400/404", instr0, pc40); end
    endtask

    task automatic test_pc_wrap();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        vectors++; if (addr1 !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL wrap_addr0 got %h want fffffff8", addr1); end
        step();
        vectors++; if (instr1 !== 32'hFFFF_FFF8 || pc41 !== 32'hFFFF_FFFC || addr1 !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_step1 got %h/%h/%h want fffffff8/fffffffc/fffffffc", instr1, pc41, addr1); end
        step();
        vectors++; if (instr1 !== 32'hFFFF_FFFC || pc41 !== 32'h0 || addr1 !== 32'h0) begin miscompares++; $display("FAIL wrap_step2 got %h/%h/%h want fffffffc/0/0", instr1, pc41, addr1); end
    endtask

    task automatic test_saturate_and_reset();
        stall = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14 || i == 15 || i == 20) begin
                vectors++;
                if (scnt2 !== 4'((i > 15) ? 15 : i)) begin miscompares++; $display("FAIL sat_count[%0d] got %0d want %0d", i, scnt2, (i > 15) ? 15 : i); end
            end
        end
        vectors++; if (scnt0 !== 16'd20) begin miscompares++; $display("FAIL wide_count got %0d want 20", scnt0); end
        rst = 1'b1; branch_taken = 1'b1; branch_target = 32'h500;
        step();
        vectors++; if (addr2 !== 32'h0 || instr2 !== 32'h0 || pc42 !== 32'h0 || valid2 !== 1'b0) begin miscompares++; $display("FAIL midstall_reset_regs got %h/%h/%h/%b want 0/0/0/0", addr2, instr2, pc42, valid2); end
        vectors++; if (scnt2 !== 4'd0 || fcnt2 !== 4'd0) begin miscompares++; $display("FAIL midstall_reset_counts got %0d/%0d want 0/0", scnt2, fcnt2); end
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        step();
        vectors++; if (instr2 !== 32'h0 || valid2 !== 1'b1 || addr2 !== 32'h4 || fcnt2 !== 4'd0) begin miscompares++; $display("FAIL no_pending_redirect got instr=%h v=%b addr=%h f=%0d want 0/1/4/0", instr2, valid2, addr2, fcnt2); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_branch();
        test_stall_priority();
        test_jump();
        test_pc_wrap();
        test_saturate_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
